keypad_time_entry: RTL and testbench

- Sits directly downstream of the keypad priority encoder. Consumes its 4-bit digit code and its all-keys-released flag.
- Debounces each press and accepts exactly one digit per press.
- Shifts accepted digits right-to-left into a 4-digit BCD MM:SS cook-time register, as on a microwave front panel.
- The register feeds the countdown timer and the display decoders.

---
 rtl/keypad_time_entry_if.sv | 27 ++
 rtl/keypad_time_entry.sv | 79 +++++++
 tb/tb_keypad_time_entry.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_time_entry_if.sv
// keypad_time_entry_if: keypad entry inputs and BCD time-register outputs.
// The beep signal exists only when KEY_BEEP_EN is defined.
interface keypad_time_entry_if;
  logic       enablen;
  logic       all_off;
  logic       clr;
  logic [3:0] D;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       key_valid;
  logic       full;
  logic       nonzero;
`ifdef KEY_BEEP_EN
  logic       beep;
  modport master(output enablen, all_off, clr, D,
                 input sec_ones, sec_tens, min_ones, min_tens, key_valid, full, nonzero, beep);
  modport slave(input enablen, all_off, clr, D,
                output sec_ones, sec_tens, min_ones, min_tens, key_valid, full, nonzero, beep);
`else
  modport master(output enablen, all_off, clr, D,
                 input sec_ones, sec_tens, min_ones, min_tens, key_valid, full, nonzero);
  modport slave(input enablen, all_off, clr, D,
                output sec_ones, sec_tens, min_ones, min_tens, key_valid, full, nonzero);
`endif
endinterface

// File: rtl/keypad_time_entry.sv
// keypad_time_entry: debounced one-digit-per-press entry into a 4-digit BCD MM:SS register.
// Define KEY_BEEP_EN to add a BEEP_CYCLES-long beep pulse on each accepted press.
module keypad_time_entry #(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef KEY_BEEP_EN
  , parameter int BEEP_CYCLES = 8
`endif
) (
  input logic clk,
  input logic clearn,
  keypad_time_entry_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE} state_t;
  state_t state, state_n;
  logic [7:0] count, count_n;
  logic [3:0] cand, cand_n;
  logic [15:0] digits;
  logic press, reach;
  assign press = !bus.enablen && !bus.all_off;
  assign reach = 9'(count) + 9'd1 >= 9'(DEBOUNCE_CYCLES);
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state <= IDLE;
      count <= '0;
      cand <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      cand <= cand_n;
    end
  end
  // The same counter times the press debounce and the release debounce.
  always_comb begin
    state_n = state;
    count_n = count;
    cand_n = cand;
    case (state)
      IDLE: if (press) begin
        cand_n = bus.D;
        count_n = 8'd1;
        state_n = DEBOUNCE_CYCLES == 1 ? ACCEPT : DEBOUNCE;
      end
      DEBOUNCE: if (press && bus.D == cand) begin
        count_n = count + 8'd1;
        state_n = reach ? ACCEPT : DEBOUNCE;
      end else begin
        count_n = '0;
        state_n = IDLE;
      end
      ACCEPT: begin
        count_n = '0;
        state_n = WAIT_RELEASE;
      end
      default: begin
        count_n = bus.all_off && !reach ? count + 8'd1 : '0;
        state_n = bus.all_off && reach ? IDLE : WAIT_RELEASE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) digits <= '0;
    else if (bus.clr) digits <= '0;
    else if (state == ACCEPT && !bus.full) digits <= {digits[11:0], cand};
  end
  assign {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = digits;
  assign bus.key_valid = state == ACCEPT;
  assign bus.full = |digits[15:12];
  assign bus.nonzero = |digits;
`ifdef KEY_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt;
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) beep_cnt <= '0;
    else if (state_n == ACCEPT) beep_cnt <= BW'(BEEP_CYCLES);
    else if (beep_cnt != '0) beep_cnt <= beep_cnt - BW'(1);
  end
  assign bus.beep = beep_cnt != '0;
`endif
endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry: table-driven and sequence checks of keypad_time_entry with DEBOUNCE_CYCLES = 4.
module tb_keypad_time_entry;
  localparam int N = 4;
  localparam int BEEP_LEN = 12;
  logic clk = 1'b0;
  logic clearn = 1'b1;
  int errors = 0;
  int checks = 0;
  keypad_time_entry_if bus();
  keypad_time_entry #(
    .DEBOUNCE_CYCLES(N)
`ifdef KEY_BEEP_EN
    , .BEEP_CYCLES(BEEP_LEN)
`endif
  ) dut (.clk(clk), .clearn(clearn), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic en_n; logic off; logic c; logic [3:0] d; int cycles;
    logic [15:0] dig; int kv; logic f; logic nz;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic en_n, logic off, logic c, logic [3:0] d, int cycles,
                              logic [15:0] dig, int kv, logic f, logic nz);
    vec_t v;
    v.en_n = en_n; v.off = off; v.c = c; v.d = d; v.cycles = cycles;
    v.dig = dig; v.kv = kv; v.f = f; v.nz = nz;
    return v;
  endfunction
  function automatic logic [15:0] digits();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic en_n, input logic off, input logic c, input logic [3:0] d);
    bus.enablen = en_n;
    bus.all_off = off;
    bus.clr = c;
    bus.D = d;
  endtask
  task automatic run(input int cycles, output int kv);
    kv = 0;
    repeat (cycles) begin
      tick();
      if (bus.key_valid) kv++;
    end
  endtask
  initial begin
    int kv, kv_at, dig_at, a1, a2, first_hi, last_hi, hi;
    bit seen;
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    #2 clearn = 1'b0;
    #1;
    check("reset digits", digits(), 16'h0000);
    check("reset key_valid", bus.key_valid, 1'b0);
    check("reset full", bus.full, 1'b0);
    check("reset nonzero", bus.nonzero, 1'b0);
`ifdef KEY_BEEP_EN
    check("reset beep", bus.beep, 1'b0);
`endif
    repeat (2) tick();
    clearn = 1'b1;
    tv.push_back(mk(0, 0, 0, 4'd1, 6, 16'h0001, 1, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h0001, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd0, 6, 16'h0010, 1, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h0010, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd3, 6, 16'h0103, 1, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h0103, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd0, 6, 16'h1030, 1, 1, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h1030, 0, 1, 1));
    tv.push_back(mk(0, 0, 0, 4'd9, 6, 16'h1030, 1, 1, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h1030, 0, 1, 1));
    tv.push_back(mk(1, 0, 0, 4'd4, 8, 16'h1030, 0, 1, 1));
    tv.push_back(mk(1, 1, 1, 4'd0, 1, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 4'd0, 6, 16'h0000, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h0000, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 4'd12, 6, 16'h000C, 1, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h000C, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd2, 3, 16'h000C, 0, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd0, 6, 16'h000C, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd5, 6, 16'h00C5, 1, 0, 1));
    tv.push_back(mk(1, 0, 0, 4'd5, 3, 16'h00C5, 0, 0, 1));
    tv.push_back(mk(1, 1, 0, 4'd0, 6, 16'h00C5, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 4'd6, 6, 16'h0C56, 1, 0, 1));
    tv.push_back(mk(0, 1, 1, 4'd0, 6, 16'h0000, 0, 0, 0));
    foreach (tv[i]) begin
      drive(tv[i].en_n, tv[i].off, tv[i].c, tv[i].d);
      run(tv[i].cycles, kv);
      check($sformatf("row%0d digits", i), digits(), tv[i].dig);
      check($sformatf("row%0d key_valid count", i), kv, tv[i].kv);
      check($sformatf("row%0d full", i), bus.full, tv[i].f);
      check($sformatf("row%0d nonzero", i), bus.nonzero, tv[i].nz);
    end
    kv = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, i % 2 == 1 ? 4'd6 : 4'd5);
      repeat (2) begin
        tick();
        if (bus.key_valid) kv++;
      end
    end
    check("bounce key_valid count", kv, 0);
    check("bounce digits", digits(), 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    run(6, kv);
    kv = 0;
    kv_at = 0;
    dig_at = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd7);
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (bus.key_valid) begin
        kv++;
        if (kv_at == 0) kv_at = e;
      end
      if (dig_at == 0 && bus.sec_ones == 4'd7) dig_at = e;
    end
    check("hold key_valid count", kv, 1);
    check("hold key_valid edge", kv_at, N);
    check("hold digit edge", dig_at, N + 1);
    check("hold digits", digits(), 16'h0007);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    run(6, kv);
    seen = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd5);
    for (int e = 0; e < 20 && !seen; e++) begin
      tick();
      seen = bus.key_valid;
    end
    check("clr accept reached", seen, 1'b1);
    bus.clr = 1'b1;
    tick();
    check("clr beats shift digits", digits(), 16'h0000);
    check("clr leaves FSM key_valid", bus.key_valid, 1'b0);
    bus.clr = 1'b0;
    run(6, kv);
    check("clr held key no reshift", digits(), 16'h0000);
    check("clr held key no pulse", kv, 0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    run(6, kv);
    drive(1'b0, 1'b0, 1'b0, 4'd8);
    run(6, kv);
    check("pre-reset digits", digits(), 16'h0008);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    run(6, kv);
    drive(1'b0, 1'b0, 1'b0, 4'd6);
    run(2, kv);
    #2 clearn = 1'b0;
    #1;
    check("mid-debounce reset digits", digits(), 16'h0000);
    check("mid-debounce reset key_valid", bus.key_valid, 1'b0);
    check("mid-debounce reset nonzero", bus.nonzero, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    clearn = 1'b1;
    run(8, kv);
    check("post-reset key_valid count", kv, 0);
    check("post-reset digits", digits(), 16'h0000);
`ifdef KEY_BEEP_EN
    a1 = 0; a2 = 0; first_hi = 0; last_hi = 0; hi = 0;
    for (int e = 1; e <= 40; e++) begin
      drive(1'b0, !(e <= 5 || (e >= 10 && e <= 14)), 1'b0, 4'd8);
      tick();
      if (bus.key_valid) begin
        if (a1 == 0) a1 = e;
        else a2 = e;
      end
      if (bus.beep) begin
        hi++;
        if (first_hi == 0) first_hi = e;
        last_hi = e;
      end
    end
    check("beep first accept", a1, N);
    check("beep second accept", a2, 13);
    check("beep start", first_hi, N);
    check("beep end", last_hi, 13 + BEEP_LEN - 1);
    check("beep length", hi, 13 - N + BEEP_LEN);
    check("beep digits", digits(), 16'h0088);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
